chian_sequencer: RTL and testbench



---
 rtl/chian_sequencer.sv | 153 +++++++++++++++
 tb/tb_chian_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chian_sequencer.sv
// chian_sequencer: control FSM for the BCH Chien-search datapath.
// Takes a finished locator from BM, pulses the datapath load, then steps it once per
// codeword position, streams flip indications for the message positions and checks the
// number of roots found against the locator degree.
module chian_sequencer #(
  parameter int unsigned N    = 16200,
  parameter int unsigned K    = 16008,
  parameter int unsigned T    = 12,
  parameter int unsigned CNTW = 14
) (
  input  logic            clkofchianseq,
  input  logic            rstofchianseq,
  input  logic            bm_valid,
  input  logic [3:0]      bm_degree,
  output logic            bm_ready,
  output logic            chian_load,
  output logic            chian_step,
  input  logic            chian_root,
  input  logic            out_ready,
  output logic            flip_valid,
  output logic            flip,
  output logic [CNTW-1:0] bit_pos,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [4:0]      root_count
);

  localparam int unsigned DEGW = 4;
  localparam int unsigned RCW  = 5;

  localparam logic [CNTW-1:0] POS_K    = CNTW'(K);
  localparam logic [CNTW-1:0] POS_LAST = CNTW'(N - 1);
  localparam logic [RCW-1:0]  RC_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] pos;
  logic [RCW-1:0]  rc;
  logic [DEGW-1:0] degree;

  logic            accept;
  logic            step;
  logic            in_msg;
  logic            deg_over_in;
  logic            deg_over;

  // Degree checks: incoming locator and the latched one.
  assign deg_over_in = (32'(bm_degree) > T);
  assign deg_over    = (32'(degree) > T);

  // Message region covers positions 0..K-1; beyond that is parity.
  assign in_msg = (pos < POS_K);

  // Counters are visible only outside reset so every output reads 0 while reset is high.
  assign bit_pos    = rstofchianseq ? '0 : pos;
  assign root_count = rstofchianseq ? '0 : rc;

  // State register.
  always_ff @(posedge clkofchianseq) begin
    if (rstofchianseq) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; everything is held low while reset is sampled high.
  always_comb begin
    state_nxt  = state;
    bm_ready   = 1'b0;
    chian_load = 1'b0;
    chian_step = 1'b0;
    flip_valid = 1'b0;
    flip       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    if (!rstofchianseq) begin
      unique case (state)
        S_IDLE: begin
          bm_ready = 1'b1;
          if (bm_valid) begin
            accept    = 1'b1;
            // An over-degree locator cannot be corrected: report failure without scanning.
            state_nxt = deg_over_in ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          busy       = 1'b1;
          chian_load = 1'b1;
          state_nxt  = S_SCAN;
        end
        S_SCAN: begin
          busy = 1'b1;
          if (in_msg) begin
            // Message positions are handshaked: the datapath only advances when accepted.
            flip_valid = 1'b1;
            flip       = chian_root;
            step       = out_ready;
          end else begin
            // Parity positions are never emitted, so they run at full rate.
            step = 1'b1;
          end
          chian_step = step;
          if (step && (pos == POS_LAST)) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          busy      = 1'b1;
          done      = 1'b1;
          fail      = deg_over || (rc != RCW'(degree));
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Position counter, saturating root counter and latched locator degree.
  always_ff @(posedge clkofchianseq) begin
    if (rstofchianseq) begin
      pos    <= '0;
      rc     <= '0;
      degree <= '0;
    end else if (accept) begin
      pos    <= '0;
      rc     <= '0;
      degree <= bm_degree;
    end else if (step) begin
      if (chian_root && (rc != RC_MAX)) begin
        rc <= rc + RCW'(1);
      end
      // The last position exits the scan; the counter does not wrap.
      if (pos != POS_LAST) begin
        pos <= pos + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chian_sequencer.sv
// Directed bench for chian_sequencer on a small build (N=16, K=12, T=3).
module tb_chian_sequencer;

  localparam int unsigned N    = 16;
  localparam int unsigned K    = 12;
  localparam int unsigned T    = 3;
  localparam int unsigned CNTW = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            bm_valid;
  logic [3:0]      bm_degree;
  logic            bm_ready;
  logic            chian_load;
  logic            chian_step;
  logic            chian_root;
  logic            out_ready;
  logic            flip_valid;
  logic            flip;
  logic [CNTW-1:0] bit_pos;
  logic            busy;
  logic            done;
  logic            fail;
  logic [4:0]      root_count;

  int n_checks = 0;
  int n_errors = 0;

  // Per-word observations collected by run_word.
  int   load_q[$];
  int   done_q[$];
  int   fail_q[$];
  int   rc_q[$];
  int   hs_pos_q[$];
  int   flip_pos_q[$];
  int   step_count;
  int   overlap;
  int   stall_hold;
  int   stray_fail;
  logic ready_at_accept;
  logic ready_after;

  chian_sequencer #(.N(N), .K(K), .T(T), .CNTW(CNTW)) dut (
    .clkofchianseq (clk),
    .rstofchianseq (rst),
    .bm_valid      (bm_valid),
    .bm_degree     (bm_degree),
    .bm_ready      (bm_ready),
    .chian_load    (chian_load),
    .chian_step    (chian_step),
    .chian_root    (chian_root),
    .out_ready     (out_ready),
    .flip_valid    (flip_valid),
    .flip          (flip),
    .bit_pos       (bit_pos),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .root_count    (root_count)
  );

  always #5 clk = ~clk;

  // Drives one word from an idle DUT. The bench models the datapath position (reset on
  // load, advanced on step) to source chian_root from the root mask. Cycle 0 is the accept.
  task automatic run_word(input logic [3:0] deg, input logic [N-1:0] roots, input int stall_pos,
                          input int stall_len, input bit park_parity, input bit hold_valid,
                          input int rst_pos, input int budget);
    int dp;
    int stall_left;
    bit rst_done;
    load_q.delete(); done_q.delete(); fail_q.delete(); rc_q.delete();
    hs_pos_q.delete(); flip_pos_q.delete();
    step_count = 0; overlap = 0; stall_hold = 0; stray_fail = 0;
    ready_at_accept = 1'b0; ready_after = 1'b0;
    dp = N; stall_left = stall_len; rst_done = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      bm_valid   = (cyc == 0) || (hold_valid && (load_q.size() < 2));
      bm_degree  = deg;
      chian_root = (dp < N) ? roots[dp] : 1'b0;
      out_ready  = 1'b1;
      if ((dp < K) && (dp == stall_pos) && (stall_left > 0)) begin
        out_ready = 1'b0;
        stall_left--;
      end
      if ((dp >= K) && (dp < N) && park_parity) out_ready = 1'b0;
      rst = 1'b0;
      if (!rst_done && (rst_pos >= 0) && (dp == rst_pos)) begin
        rst = 1'b1;
        rst_done = 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) ready_at_accept = bm_ready;
      if (chian_load) load_q.push_back(cyc);
      if (chian_step) step_count++;
      if (chian_load && chian_step) overlap++;
      if (flip_valid && out_ready) begin
        hs_pos_q.push_back(int'(bit_pos));
        if (flip) flip_pos_q.push_back(int'(bit_pos));
      end
      if (!out_ready && flip_valid && !chian_step && (bit_pos == CNTW'(stall_pos))) stall_hold++;
      if (done) begin
        done_q.push_back(cyc);
        fail_q.push_back(int'(fail));
        rc_q.push_back(int'(root_count));
      end
      if (fail && !done) stray_fail++;
      if ((done_q.size() > 0) && (cyc == done_q[0] + 1)) ready_after = bm_ready;
      if (chian_load) dp = 0;
      else if (chian_step) dp++;
      @(posedge clk); #1;
    end
    bm_valid = 1'b0; rst = 1'b0; out_ready = 1'b1; chian_root = 1'b0;
  endtask

  task automatic test_reset();
    logic [CNTW+13:0] outs;
    bit seen;
    rst = 1'b1; bm_valid = 1'b1; bm_degree = 4'd0; out_ready = 1'b1; chian_root = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      outs = {bm_ready, chian_load, chian_step, flip_valid, flip, busy, done, fail, bit_pos, root_count};
      n_checks++;
      if (outs !== '0) begin n_errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    end
    rst = 1'b0; chian_root = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bm_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after_release: got %b want 1", bm_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({chian_load, busy} !== 2'b11) begin n_errors++; $display("FAIL reset_accept_load: got %b want 11", {chian_load, busy}); end
    bm_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; (i < 40) && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) begin n_errors++; $display("FAIL reset_word_done: got %b want 1", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_errors();
    int got;
    run_word(4'd0, '0, -1, 0, 1'b0, 1'b0, -1, 22);
    n_checks++;
    if (ready_at_accept !== 1'b1) begin n_errors++; $display("FAIL noerr_ready: got %b want 1", ready_at_accept); end
    got = (load_q.size() == 1) ? load_q[0] : -1;
    n_checks++;
    if (got !== 1) begin n_errors++; $display("FAIL noerr_load_cycle: got %0d want 1", got); end
    n_checks++;
    if (hs_pos_q.size() !== K) begin n_errors++; $display("FAIL noerr_flip_beats: got %0d want %0d", hs_pos_q.size(), K); end
    for (int i = 0; i < int'(K); i++) begin
      got = (i < hs_pos_q.size()) ? hs_pos_q[i] : -1;
      n_checks++;
      if (got !== i) begin n_errors++; $display("FAIL noerr_bit_pos[%0d]: got %0d want %0d", i, got, i); end
    end
    n_checks++;
    if (flip_pos_q.size() !== 0) begin n_errors++; $display("FAIL noerr_flips: got %0d want 0", flip_pos_q.size()); end
    n_checks++;
    if (step_count !== 16) begin n_errors++; $display("FAIL noerr_steps: got %0d want 16", step_count); end
    n_checks++;
    if (overlap !== 0) begin n_errors++; $display("FAIL noerr_load_step_overlap: got %0d want 0", overlap); end
    got = (done_q.size() == 1) ? done_q[0] : -1;
    n_checks++;
    if (got !== 18) begin n_errors++; $display("FAIL noerr_done_cycle: got %0d want 18", got); end
    got = (fail_q.size() == 1) ? fail_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL noerr_fail: got %0d want 0", got); end
    got = (rc_q.size() == 1) ? rc_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL noerr_root_count: got %0d want 0", got); end
    n_checks++;
    if (ready_after !== 1'b1) begin n_errors++; $display("FAIL noerr_ready_after_done: got %b want 1", ready_after); end
  endtask

  task automatic test_correctable();
    logic [N-1:0] m;
    int got;
    m = '0; m[3] = 1'b1; m[14] = 1'b1;
    run_word(4'd2, m, -1, 0, 1'b0, 1'b0, -1, 22);
    n_checks++;
    if (flip_pos_q.size() !== 1) begin n_errors++; $display("FAIL corr_flip_count: got %0d want 1", flip_pos_q.size()); end
    got = (flip_pos_q.size() > 0) ? flip_pos_q[0] : -1;
    n_checks++;
    if (got !== 3) begin n_errors++; $display("FAIL corr_flip_pos: got %0d want 3", got); end
    got = (fail_q.size() == 1) ? fail_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL corr_fail: got %0d want 0", got); end
    got = (rc_q.size() == 1) ? rc_q[0] : -1;
    n_checks++;
    if (got !== 2) begin n_errors++; $display("FAIL corr_root_count: got %0d want 2", got); end
    n_checks++;
    if (stray_fail !== 0) begin n_errors++; $display("FAIL corr_fail_outside_done: got %0d want 0", stray_fail); end
  endtask

  task automatic test_mismatch();
    logic [N-1:0] m;
    int got;
    m = '0; m[5] = 1'b1; m[7] = 1'b1;
    run_word(4'd3, m, -1, 0, 1'b0, 1'b0, -1, 22);
    n_checks++;
    if (flip_pos_q.size() !== 2) begin n_errors++; $display("FAIL mism_flip_count: got %0d want 2", flip_pos_q.size()); end
    got = (fail_q.size() == 1) ? fail_q[0] : -1;
    n_checks++;
    if (got !== 1) begin n_errors++; $display("FAIL mism_fail: got %0d want 1", got); end
    got = (rc_q.size() == 1) ? rc_q[0] : -1;
    n_checks++;
    if (got !== 2) begin n_errors++; $display("FAIL mism_root_count: got %0d want 2", got); end
    got = (done_q.size() == 1) ? done_q[0] : -1;
    n_checks++;
    if (got !== 18) begin n_errors++; $display("FAIL mism_done_cycle: got %0d want 18", got); end
  endtask

  task automatic test_degree_over();
    int got;
    run_word(4'd13, '0, -1, 0, 1'b0, 1'b0, -1, 5);
    n_checks++;
    if (load_q.size() !== 0) begin n_errors++; $display("FAIL over_load_count: got %0d want 0", load_q.size()); end
    got = (done_q.size() == 1) ? done_q[0] : -1;
    n_checks++;
    if (got !== 1) begin n_errors++; $display("FAIL over_done_cycle: got %0d want 1", got); end
    got = (fail_q.size() == 1) ? fail_q[0] : -1;
    n_checks++;
    if (got !== 1) begin n_errors++; $display("FAIL over_fail: got %0d want 1", got); end
    got = (rc_q.size() == 1) ? rc_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL over_root_count_cleared: got %0d want 0", got); end
    n_checks++;
    if ((step_count + hs_pos_q.size()) !== 0) begin n_errors++; $display("FAIL over_no_scan: got %0d want 0", step_count + hs_pos_q.size()); end
    n_checks++;
    if (ready_after !== 1'b1) begin n_errors++; $display("FAIL over_ready_after_done: got %b want 1", ready_after); end
  endtask

  task automatic test_backpressure();
    int got;
    run_word(4'd0, '0, 6, 4, 1'b1, 1'b0, -1, 26);
    n_checks++;
    if (stall_hold !== 4) begin n_errors++; $display("FAIL bp_held_cycles: got %0d want 4", stall_hold); end
    n_checks++;
    if (hs_pos_q.size() !== K) begin n_errors++; $display("FAIL bp_flip_beats: got %0d want %0d", hs_pos_q.size(), K); end
    got = (hs_pos_q.size() > 7) ? hs_pos_q[7] : -1;
    n_checks++;
    if (got !== 7) begin n_errors++; $display("FAIL bp_pos_after_stall: got %0d want 7", got); end
    n_checks++;
    if (step_count !== 16) begin n_errors++; $display("FAIL bp_steps: got %0d want 16", step_count); end
    got = (done_q.size() == 1) ? done_q[0] : -1;
    n_checks++;
    if (got !== 22) begin n_errors++; $display("FAIL bp_done_cycle: got %0d want 22", got); end
  endtask

  task automatic test_back_to_back();
    int got;
    run_word(4'd0, '0, -1, 0, 1'b0, 1'b1, -1, 42);
    got = (load_q.size() == 2) ? load_q[1] : -1;
    n_checks++;
    if (got !== 20) begin n_errors++; $display("FAIL b2b_second_load: got %0d want 20", got); end
    got = (done_q.size() == 2) ? done_q[1] : -1;
    n_checks++;
    if (got !== 37) begin n_errors++; $display("FAIL b2b_second_done: got %0d want 37", got); end
    n_checks++;
    if (hs_pos_q.size() !== 2 * K) begin n_errors++; $display("FAIL b2b_flip_beats: got %0d want %0d", hs_pos_q.size(), 2 * K); end
  endtask

  task automatic test_reset_mid_scan();
    logic [N-1:0] m;
    int got;
    m = '0; m[2] = 1'b1;
    run_word(4'd1, m, -1, 0, 1'b0, 1'b0, 9, 20);
    n_checks++;
    if (done_q.size() !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d want 0", done_q.size()); end
    n_checks++;
    if (hs_pos_q.size() !== 9) begin n_errors++; $display("FAIL midrst_beats_before_reset: got %0d want 9", hs_pos_q.size()); end
    @(negedge clk);
    n_checks++;
    if ({bm_ready, busy, root_count} !== {1'b1, 1'b0, 5'd0}) begin
      n_errors++; $display("FAIL midrst_idle_state: got %b want 1000000", {bm_ready, busy, root_count});
    end
    @(posedge clk); #1;
    run_word(4'd0, '0, -1, 0, 1'b0, 1'b0, -1, 22);
    got = (hs_pos_q.size() > 0) ? hs_pos_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL midrst_restart_pos: got %0d want 0", got); end
    got = (rc_q.size() == 1) ? rc_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL midrst_restart_root_count: got %0d want 0", got); end
    got = (fail_q.size() == 1) ? fail_q[0] : -1;
    n_checks++;
    if (got !== 0) begin n_errors++; $display("FAIL midrst_restart_fail: got %0d want 0", got); end
  endtask

  // Test sequence.
  initial begin
    rst = 1'b1; bm_valid = 1'b0; bm_degree = 4'd0; out_ready = 1'b1; chian_root = 1'b0;
    test_reset();
    test_no_errors();
    test_correctable();
    test_mismatch();
    test_degree_over();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
